// File: rtl/pass_request_gen.sv
// pass_request_gen
// ----------------
// Pedestrian-request front end sitting directly upstream of the traffic_light
// controller's pass_request input. A raw crossing button is synchronised,
// debounced and turned into a single press event. The press is latched and
// pass_request is raised only while the controller shows green with more than
// 10 cycles of countdown left. The request drops once the controller has cut
// the countdown (served) or after HOLD_MAX cycles without effect (dropped).
//
// Optional feature macro: PASS_REQ_COOLDOWN_EN
//   defined   : every served/dropped exit enters a COOLDOWN_CYCLES lockout,
//               during which busy is high and presses are discarded.
//   undefined : REQ returns straight to IDLE and busy is tied low.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles required to accept a button level (>=2)
//   HOLD_MAX         maximum cycles pass_request stays high
//   COOLDOWN_CYCLES  lockout length after service (macro builds only)
//
// Ports
//   clk           in   sole clock, rising edge
//   rst           in   synchronous active-high reset
//   btn_raw       in   asynchronous button, high = pressed
//   green         in   controller green lamp
//   clock[7:0]    in   controller countdown, unsigned
//   pass_request  out  registered request level to the controller
//   req_pending   out  press latched and not yet served (ARMED or REQ)
//   served        out  one-cycle pulse when the request is honoured
//   dropped       out  one-cycle pulse when the request times out
//   busy          out  high during COOLDOWN
//   state_dbg     out  current FSM state encoding (IDLE=0 ARMED=1 REQ=2 COOLDOWN=3)
//
// Handshake: pass_request is a level, not a valid/ready pair. It is held high
// for as long as this block wants the crossing; the controller acknowledges
// implicitly by reloading its countdown to 10, which closes the window and
// makes this block drop the level with a served pulse on the same edge.
module pass_request_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_MAX        = 64,
  parameter int COOLDOWN_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       green,
  input  logic [7:0] clock,
  output logic       pass_request,
  output logic       req_pending,
  output logic       served,
  output logic       dropped,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLD_MAX > 1)        ? $clog2(HOLD_MAX)        : 1;
  localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    REQ      = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  // Where REQ goes after served/dropped, and whether busy is ever driven.
`ifdef PASS_REQ_COOLDOWN_EN
  localparam state_t EXIT_STATE = COOLDOWN;
  localparam logic   BUSY_EN    = 1'b1;
`else
  localparam state_t EXIT_STATE = IDLE;
  localparam logic   BUSY_EN    = 1'b0;
`endif

  // Synchroniser and debouncer
  logic          s1, s2;
  logic          btn_db, btn_db_q;
  logic [DW-1:0] db_cnt;
  logic          press;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      s1       <= btn_raw;
      s2       <= s1;
      btn_db_q <= btn_db;
      if (s2 != btn_db) begin
        // Accept the new level only after it has differed long enough.
        if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          btn_db <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Rising edge of the debounced level only; release is ignored.
  assign press = btn_db & ~btn_db_q;

  // Request FSM
  state_t        state, state_next;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] cd_cnt;
  logic          open_window;
  logic          served_next, dropped_next;

  assign open_window = green & (clock > 8'd10);

  always_comb begin
    state_next   = state;
    served_next  = 1'b0;
    dropped_next = 1'b0;
    case (state)
      IDLE: begin
        if (press) state_next = open_window ? REQ : ARMED;
      end
      ARMED: begin
        if (open_window) state_next = REQ;
      end
      REQ: begin
        // A closed window means the controller acted: this wins over timeout.
        if (!open_window) begin
          served_next = 1'b1;
          state_next  = EXIT_STATE;
        end else if (hold_cnt == HW'(HOLD_MAX - 1)) begin
          dropped_next = 1'b1;
          state_next   = EXIT_STATE;
        end
      end
      COOLDOWN: begin
        if (cd_cnt == CW'(COOLDOWN_CYCLES - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      cd_cnt       <= '0;
      pass_request <= 1'b0;
      req_pending  <= 1'b0;
      served       <= 1'b0;
      dropped      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state <= state_next;
      // Counters run only while staying in their state and clear on any entry.
      hold_cnt <= (state == REQ && state_next == REQ) ? hold_cnt + HW'(1) : '0;
      cd_cnt   <= (state == COOLDOWN && state_next == COOLDOWN) ? cd_cnt + CW'(1) : '0;
      // Outputs follow the state being entered so they change on that edge.
      pass_request <= (state_next == REQ);
      req_pending  <= (state_next == ARMED) || (state_next == REQ);
      served       <= served_next;
      dropped      <= dropped_next;
      busy         <= BUSY_EN & (state_next == COOLDOWN);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pass_request_gen.sv
module tb_pass_request_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       green;
  logic [7:0] clock;
  logic       pass_request, req_pending, served, dropped, busy;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outcome per accepted press: {served, dropped}
  logic [1:0] exp_q[$];

  pass_request_gen #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_MAX(8),
    .COOLDOWN_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .green(green),
    .clock(clock),
    .pass_request(pass_request),
    .req_pending(req_pending),
    .served(served),
    .dropped(dropped),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, required end before 100000");
    $fatal(1, "watchdog expired");
  end

  // Helpers
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a clean press from an idle, released button and check the
  // press latency: nothing through edge 6, FSM reacts at edge 7.
  task automatic press_expect(input string tag, input logic exp_req, input logic [1:0] outcome);
    exp_q.push_back(outcome);
    btn_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check({tag, "_early"}, 32'({pass_request, req_pending}), 32'd0);
    end
    tick();
    check({tag, "_edge7"}, 32'({pass_request, req_pending}), 32'({exp_req, 1'b1}));
  endtask

  task automatic release_and_settle(input int n);
    btn_raw = 1'b0;
    repeat (n) tick();
  endtask

  // Scoreboard: every served/dropped pulse consumes one expected outcome.
  always @(negedge clk) begin
    if (served || dropped) begin
      if (exp_q.size() == 0)
        check("unexpected_pulse", 32'({served, dropped}), 32'd0);
      else
        check("outcome", 32'({served, dropped}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int hi;
    // Reset held three cycles with the button already pressed
    rst     = 1'b1;
    btn_raw = 1'b1;
    green   = 1'b1;
    clock   = 8'd40;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", 32'({pass_request, req_pending, served, dropped, busy}), 32'd0);
      check("reset_state", 32'(state_dbg), 32'd0);
    end
    rst = 1'b0;

    // Open window: request at edge 7, controller reload closes it
    press_expect("open_window", 1'b1, 2'b10);
    tick();
    check("open_hold", 32'(pass_request), 32'd1);
    clock = 8'd10;
    tick();
    check("open_served", 32'({pass_request, served, req_pending}), 32'b010);
    btn_raw = 1'b0;
`ifdef PASS_REQ_COOLDOWN_EN
    check("busy_start", 32'(busy), 32'd1);
    for (int i = 1; i <= 19; i++) begin
      tick();
      check("busy_hold", 32'({busy, served}), 32'b10);
      // Re-press lands at edge 21, inside the lockout
      if (i == 6) btn_raw = 1'b1;
    end
    tick();
    check("busy_end", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("cooldown_press_lost", 32'({pass_request, req_pending}), 32'd0);
    end
`else
    check("busy_tied_low", 32'(busy), 32'd0);
    clock = 8'd40;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("no_cd_wait", 32'({busy, pass_request}), 32'd0);
      if (i == 6) begin
        btn_raw = 1'b1;
        exp_q.push_back(2'b10);
      end
    end
    tick();
    check("no_cd_second_req", 32'({pass_request, req_pending}), 32'b11);
    clock = 8'd10;
    tick();
    check("no_cd_second_served", 32'({pass_request, served}), 32'b01);
`endif
    release_and_settle(10);

    // Bounce: toggling every cycle, then a too-short 3-cycle pulse
    green = 1'b1;
    clock = 8'd40;
    for (int i = 0; i < 10; i++) begin
      btn_raw = ~btn_raw;
      tick();
    end
    btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bounce_ignored", 32'({pass_request, req_pending}), 32'd0);
    end
    btn_raw = 1'b1;
    repeat (3) tick();
    btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("short_pulse_ignored", 32'({pass_request, req_pending}), 32'd0);
    end

    // Deferred: press while red, window opens later
    green = 1'b0;
    clock = 8'd0;
    press_expect("deferred", 1'b0, 2'b10);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("deferred_armed", 32'({pass_request, req_pending}), 32'b01);
    end
    btn_raw = 1'b0;
    green   = 1'b1;
    clock   = 8'd60;
    tick();
    check("deferred_req", 32'({pass_request, req_pending}), 32'b11);
    clock = 8'd10;
    tick();
    check("deferred_served", 32'({pass_request, served, req_pending}), 32'b010);
    release_and_settle(25);

    // Timeout: countdown frozen at 50, request abandoned after HOLD_MAX
    clock = 8'd50;
    press_expect("timeout", 1'b1, 2'b01);
    hi = 1;
    for (int i = 0; i < 20 && pass_request; i++) begin
      tick();
      if (pass_request) hi++;
    end
    check("timeout_high_cycles", 32'(hi), 32'd8);
    check("timeout_pulse", 32'({pass_request, served, dropped}), 32'b001);
    tick();
    check("dropped_one_cycle", 32'(dropped), 32'd0);
    release_and_settle(25);

    // Reset in the middle of REQ: level falls, no pulse
    press_expect("mid_req", 1'b1, 2'b00);
    void'(exp_q.pop_back());
    rst     = 1'b1;
    btn_raw = 1'b0;
    tick();
    check("mid_req_reset", 32'({pass_request, req_pending, served, dropped, busy}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_reset_quiet", 32'({pass_request, served, dropped}), 32'd0);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
